// File: rtl/pipeline_stage_register.sv
// Reusable handshaked pipeline register with flush and optional skid entry.
// Bubbles are written into the registers, so the outputs never pass through a mux.
module pipeline_stage_register #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 16,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter bit SKID = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [CTRL_WIDTH-1:0] inCtrl,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CTRL_WIDTH-1:0] outCtrl,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_main_data;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl;

  logic w_acc;
  logic w_rel;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_main_clr;
  logic w_skid_ld;
  logic w_skid_clr;

  // Skid mode decodes readiness from registered state only.
  always_comb begin
    if (SKID) begin
      inReady = (r_state != S_TWO);
    end else begin
      inReady = (r_state == S_EMPTY) || outReady;
    end
  end

  assign outValid = (r_state != S_EMPTY);
  assign outData  = r_main_data;
  assign outCtrl  = r_main_ctrl;
  assign w_acc    = inValid && inReady;
  assign w_rel    = outValid && outReady;

  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      S_EMPTY: occupancy = 2'd0;
      S_ONE:   occupancy = 2'd1;
      S_TWO:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_main_clr     = 1'b0;
    w_skid_ld      = 1'b0;
    w_skid_clr     = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_main_ld_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_rel) begin
            w_main_ld_in = 1'b1;
          end else if (w_acc && SKID) begin
            w_skid_ld   = 1'b1;
            w_state_nxt = S_TWO;
          end else if (w_rel) begin
            w_main_clr  = 1'b1;
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_rel) begin
            w_main_ld_skid = 1'b1;
            w_skid_clr     = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_clr  = 1'b1;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_clr) begin
        r_main_data <= '0;
        r_main_ctrl <= CTRL_BUBBLE;
      end else if (w_main_ld_in) begin
        r_main_data <= inData;
        r_main_ctrl <= inCtrl;
      end else if (w_main_ld_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_skid_clr) begin
        r_skid_data <= '0;
        r_skid_ctrl <= CTRL_BUBBLE;
      end else if (w_skid_ld) begin
        r_skid_data <= inData;
        r_skid_ctrl <= inCtrl;
      end
    end
  end

endmodule

// File: doc/pipeline_stage_register.md
# pipeline_stage_register

Parametrised, handshaked pipeline stage register for the RISC-V pipeline, intended to replace the fixed per-stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback) with a single reusable block. It carries an opaque data payload plus a control field. It adds valid/ready flow control (stall), synchronous flush with bubble insertion, and an optional second skid entry, so upstream `inReady` has no combinational path from `outReady`.

## Interface
- `DATA_WIDTH`, default 128: payload width (PC, operands, immediate, register indices, func fields, packed by the instantiating stage).
- `CTRL_WIDTH`, default 16: control-field width (enables, ALU select, mux selects).
- `CTRL_BUBBLE`, default all zeros: control value presented for a bubble or empty stage; must encode "no side effects".
- `SKID`, default 1: 1 = two-entry skid mode with registered `inReady`; 0 = single-entry mode with combinational `inReady`.

Ports:
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `flush` input 1: synchronous kill of all held entries (branch mispredict / jump redirect).
- `inValid` input 1: upstream offers an entry.
- `inReady` output 1: stage can accept an entry this cycle.
- `inData` input DATA_WIDTH: upstream payload.
- `inCtrl` input CTRL_WIDTH: upstream control field.
- `outValid` output 1: stage presents a valid entry.
- `outReady` input 1: downstream accepts the presented entry.
- `outData` output DATA_WIDTH: presented payload.
- `outCtrl` output CTRL_WIDTH: presented control field; equals `CTRL_BUBBLE` whenever `outValid` = 0.
- `occupancy` output 2: number of held entries (0–2; max 1 when `SKID` = 0).

## Operation
- Accept (`acc`) = `inValid && inReady`. Release (`rel`) = `outValid && outReady`.
- Storage: a main entry (drives outputs) and, in skid mode only, a skid entry. Each entry holds data, ctrl, and a valid bit.
- States: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid; skid mode only).
- EMPTY transitions:
  - `acc`: main ← in, go to ONE.
  - otherwise: stay in EMPTY.
- ONE transitions:
  - `acc && rel`: main ← in, stay in ONE.
  - `acc && !rel`: skid ← in, go to TWO (skid mode only).
  - `!acc && rel`: go to EMPTY.
  - neither: hold.
- TWO transitions:
  - `rel`: main ← skid, go to ONE.
  - otherwise: hold.
  - No accept is possible in TWO.
- `inReady`:
  - Skid mode: `inReady` = (state ≠ TWO), decoded from registered state only.
  - Single-entry mode: `inReady` = (state = EMPTY) || `outReady`.
- Clearing: whenever an entry becomes invalid (drain, flush, reset), its data ← 0 and its ctrl ← `CTRL_BUBBLE`. Outputs are therefore always register-driven, and the bubble value appears without an output mux.
- Flush:
  - Next state is EMPTY; all entries are cleared.
  - Any `acc` in the flush cycle counts as a completed handshake upstream, but the entry is discarded.
  - Any `rel` in the flush cycle completes normally downstream.
- Priority: `reset` > `flush` > normal transitions.
- Held outputs: while `outValid` && !`outReady`, `outData` and `outCtrl` are stable, with no glitch across cycles.
- `occupancy`: EMPTY → 0, ONE → 1, TWO → 2.

## Timing
- Reset values, on the first edge with `reset` = 1:
  - `outValid` = 0, `outData` = 0, `outCtrl` = `CTRL_BUBBLE`, `occupancy` = 0, state = EMPTY.
  - `inReady` = 1 from the cycle after reset deasserts.
  - Handshakes during reset-asserted cycles are ignored.
- Latency: an entry accepted at edge N appears on the outputs after edge N (visible in cycle N+1) when the stage was EMPTY, or when ONE with a simultaneous `rel`.
- Throughput: one entry per cycle sustained in both modes while `outReady` = 1.
- Skid mode:
  - Downstream stall for k cycles: at most one extra entry is absorbed; `inReady` drops the cycle after the skid fills.
  - `inReady` rises the cycle after the first `rel`.
- Single-entry mode: `inReady` follows `outReady` combinationally; no extra buffering.
- Reset mid-stream: all entries are lost; behaviour is identical to the flush case apart from priority.

## Test plan
- **Reset:** assert `reset` with `inValid` = 1 and `inData` = 0xA5 → `outValid` = 0, `outCtrl` = `CTRL_BUBBLE`, `occupancy` = 0; `inReady` = 1 one cycle after release.
- **Streaming:** `outReady` = 1; feed data 1, 2, 3, … on consecutive cycles → outputs 1, 2, 3, … one cycle later, no gaps; `occupancy` stays 1.
- **Stall (`SKID` = 1):** hold `outReady` = 0 while sending D1, D2, D3 → D1 and D2 accepted, `inReady` = 0 after the second accept, D3 held upstream, `occupancy` = 2. Release `outReady` → outputs D1, D2, D3 in order, none lost or duplicated.
- **Flush in TWO:** assert `flush` with `inValid` = 1 → next cycle `outValid` = 0, `outData` = 0, `outCtrl` = `CTRL_BUBBLE`, `occupancy` = 0; the offered entry never appears.
- **`SKID` = 0:** `outReady` = 0 with the stage full → `inReady` = 0 in the same cycle. Raise `outReady` → `inReady` = 1 in the same cycle, and the new entry replaces the old at the next edge.
- **Random:** random `inValid`/`outReady`/`flush` against a scoreboard → order preserved, no drops except flushed entries, and `outCtrl` = `CTRL_BUBBLE` on every cycle where `outValid` = 0.
